// File: rtl/ahb3lite_sram_slave_pkg.sv
// Shared AHB3-Lite encodings and field widths for the on-chip SRAM slave.
package ahb3lite_sram_slave_pkg;

   localparam int unsigned HTRANS_SIZE = 2;
   localparam int unsigned HSIZE_SIZE  = 3;
   localparam int unsigned HBURST_SIZE = 3;
   localparam int unsigned HPROT_SIZE  = 4;

   localparam logic [HTRANS_SIZE-1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [HTRANS_SIZE-1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [HTRANS_SIZE-1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [HTRANS_SIZE-1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [HSIZE_SIZE-1:0] HSIZE_BYTE  = 3'd0;
   localparam logic [HSIZE_SIZE-1:0] HSIZE_HWORD = 3'd1;
   localparam logic [HSIZE_SIZE-1:0] HSIZE_WORD  = 3'd2;
   localparam logic [HSIZE_SIZE-1:0] HSIZE_DWORD = 3'd3;

endpackage

// File: rtl/ahb3lite_sram_slave_if.sv
// AHB3-Lite slave-port bundle; master drives address/control/write data, slave answers.
interface ahb3lite_sram_slave_if
   import ahb3lite_sram_slave_pkg::*;
#(
   parameter int unsigned HADDR_SIZE = 32,
   parameter int unsigned HDATA_SIZE = 32
);
   logic                   HSEL;
   logic [HADDR_SIZE-1:0]  HADDR;
   logic [HDATA_SIZE-1:0]  HWDATA;
   logic [HDATA_SIZE-1:0]  HRDATA;
   logic                   HWRITE;
   logic [HSIZE_SIZE-1:0]  HSIZE;
   logic [HBURST_SIZE-1:0] HBURST;
   logic [HPROT_SIZE-1:0]  HPROT;
   logic [HTRANS_SIZE-1:0] HTRANS;
   logic                   HMASTLOCK;
   logic                   HREADY;
   logic                   HREADYOUT;
   logic                   HRESP;

   modport master (
      output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );

endinterface

// File: rtl/ahb3lite_sram_slave_mem.sv
// SRAM array: per-byte write enables on the clock edge, asynchronous word read.
module ahb3lite_sram_slave_mem #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned WORDS     = 1024,
   parameter string       INIT_FILE = ""
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [DATA_W/8-1:0]      be,
   input  logic [$clog2(WORDS)-1:0] addr,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [WORDS];

   // Contents survive reset by design; only the bus-side state is cleared.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < DATA_W / 8; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM target: configurable wait states, two-cycle ERROR response, byte-lane writes.
module ahb3lite_sram_slave
   import ahb3lite_sram_slave_pkg::*;
#(
   parameter int unsigned HADDR_SIZE  = 32,
   parameter int unsigned HDATA_SIZE  = 32,
   parameter int unsigned MEM_BYTES   = 4096,
   parameter int unsigned WAIT_STATES = 0,
   parameter string       INIT_FILE   = ""
) (
   input logic                  HCLK,
   input logic                  HRESET,
   ahb3lite_sram_slave_if.slave bus
);

   localparam int unsigned BE_W      = HDATA_SIZE / 8;
   localparam int unsigned LANE_BITS = $clog2(BE_W);
   localparam int unsigned AW        = $clog2(MEM_BYTES);
   localparam int unsigned WORDS     = MEM_BYTES / BE_W;
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

   typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

   // A byte is enabled when it falls in the same size-aligned group as the addressed lane.
   function automatic logic [BE_W-1:0] byte_en(input logic [HSIZE_SIZE-1:0] size,
                                               input logic [LANE_BITS-1:0]  lane);
      logic [BE_W-1:0] be;
      for (int i = 0; i < int'(BE_W); i++) begin
         be[i] = ((i >> size) == (int'(lane) >> size));
      end
      return be;
   endfunction

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [AW-1:0]          addr_q;
   logic [HSIZE_SIZE-1:0]  size_q;
   logic                   write_q;
   logic                   load;

   logic                   accept;
   logic                   range_err, size_err, align_err, req_err;
   logic [6:0]             align_mask;
   logic                   mem_we;
   logic [HDATA_SIZE-1:0]  mem_rdata;
   logic                   unused_bits;

   assign accept     = bus.HSEL & bus.HREADY & bus.HTRANS[1];
   assign range_err  = {1'b0, bus.HADDR} >= (HADDR_SIZE + 1)'(MEM_BYTES);
   assign size_err   = bus.HSIZE > HSIZE_SIZE'(LANE_BITS);
   assign align_mask = (7'd1 << bus.HSIZE) - 7'd1;
   assign align_err  = |(bus.HADDR[6:0] & align_mask);
   assign req_err    = range_err | size_err | align_err;

   assign unused_bits = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE, DATA, ERR2: begin
            if (accept) begin
               load = 1'b1;
               if (req_err) begin
                  state_d = ERR1;
               end else if (WAIT_STATES != 0) begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LOAD;
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = DATA;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ERR1:    state_d = ERR2;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load) begin
            addr_q  <= bus.HADDR[AW-1:0];
            size_q  <= bus.HSIZE;
            write_q <= bus.HWRITE;
         end
      end
   end

   // Write commits only on the final OKAY cycle, so reset during waits drops it.
   assign mem_we = (state_q == DATA) && write_q;

   ahb3lite_sram_slave_mem #(
      .DATA_W    (HDATA_SIZE),
      .WORDS     (WORDS),
      .INIT_FILE (INIT_FILE)
   ) u_mem (
      .clk   (HCLK),
      .we    (mem_we),
      .be    (byte_en(size_q, addr_q[LANE_BITS-1:0])),
      .addr  (addr_q[AW-1:LANE_BITS]),
      .wdata (bus.HWDATA),
      .rdata (mem_rdata)
   );

   assign bus.HREADYOUT = !(state_q == WAIT || state_q == ERR1);
   assign bus.HRESP     = (state_q == ERR1) || (state_q == ERR2);
   assign bus.HRDATA    = ((state_q == WAIT || state_q == DATA) && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench for ahb3lite_sram_slave: one zero-wait and one two-wait-state instance.
module tb_ahb3lite_sram_slave;
   import ahb3lite_sram_slave_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hsel = 1'b0;
   logic        hwrite = 1'b0;
   logic        stall = 1'b0;
   logic [31:0] haddr = '0;
   logic [31:0] hwdata = '0;
   logic [2:0]  hsize = HSIZE_WORD;
   logic [1:0]  htrans = HTRANS_IDLE;
   int          target = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus0 ();
   ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus2 ();

   assign bus0.HSEL      = hsel && (target == 0);
   assign bus0.HADDR     = haddr;
   assign bus0.HWDATA    = hwdata;
   assign bus0.HWRITE    = hwrite;
   assign bus0.HSIZE     = hsize;
   assign bus0.HBURST    = '0;
   assign bus0.HPROT     = '0;
   assign bus0.HTRANS    = htrans;
   assign bus0.HMASTLOCK = 1'b0;
   assign bus0.HREADY    = !stall && bus0.HREADYOUT;

   assign bus2.HSEL      = hsel && (target == 2);
   assign bus2.HADDR     = haddr;
   assign bus2.HWDATA    = hwdata;
   assign bus2.HWRITE    = hwrite;
   assign bus2.HSIZE     = hsize;
   assign bus2.HBURST    = '0;
   assign bus2.HPROT     = '0;
   assign bus2.HTRANS    = htrans;
   assign bus2.HMASTLOCK = 1'b0;
   assign bus2.HREADY    = !stall && bus2.HREADYOUT;

   ahb3lite_sram_slave #(.MEM_BYTES(4096), .WAIT_STATES(0)) dut0 (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus0.slave)
   );

   ahb3lite_sram_slave #(.MEM_BYTES(4096), .WAIT_STATES(2)) dut2 (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus2.slave)
   );

   logic        cur_ready, cur_resp;
   logic [31:0] cur_rdata;
   assign cur_ready = (target == 0) ? bus0.HREADYOUT : bus2.HREADYOUT;
   assign cur_resp  = (target == 0) ? bus0.HRESP     : bus2.HRESP;
   assign cur_rdata = (target == 0) ? bus0.HRDATA    : bus2.HRDATA;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      hsel   = 1'b0;
      htrans = HTRANS_IDLE;
      hwrite = 1'b0;
      haddr  = '0;
      hsize  = HSIZE_WORD;
   endtask

   task automatic addr_phase(input logic w, input logic [31:0] a, input logic [2:0] s);
      hsel   = 1'b1;
      htrans = HTRANS_NONSEQ;
      hwrite = w;
      haddr  = a;
      hsize  = s;
   endtask

   task automatic finish_xfer(output logic [31:0] d);
      bit done = 0;
      d = '0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (cur_ready) begin
            done = 1;
            d    = cur_rdata;
         end
      end
      n_checks++;
      if (!done) $display("FAIL xfer_timeout: HREADYOUT=0 required=1 within 20 cycles");
      else       n_pass++;
      step();
   endtask

   task automatic do_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      logic [31:0] dummy;
      addr_phase(1'b1, a, s);
      step();
      hwdata = d;
      set_idle();
      finish_xfer(dummy);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d);
      addr_phase(1'b0, a, HSIZE_WORD);
      step();
      set_idle();
      finish_xfer(d);
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({bus0.HREADYOUT, bus0.HRESP, bus0.HRDATA} !== {1'b1, 1'b0, 32'h0})
         $display("FAIL reset_ws0: got rdy=%b resp=%b rdata=%h required 1 0 0",
                  bus0.HREADYOUT, bus0.HRESP, bus0.HRDATA);
      else n_pass++;
      n_checks++;
      if ({bus2.HREADYOUT, bus2.HRESP, bus2.HRDATA} !== {1'b1, 1'b0, 32'h0})
         $display("FAIL reset_ws2: got rdy=%b resp=%b rdata=%h required 1 0 0",
                  bus2.HREADYOUT, bus2.HRESP, bus2.HRDATA);
      else n_pass++;
      #10 rst = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      target = 0;
      addr_phase(1'b1, 32'h10, HSIZE_WORD);
      step();
      hwdata = 32'hDEADBEEF;
      addr_phase(1'b0, 32'h10, HSIZE_WORD);
      @(negedge clk);
      n_checks++;
      if (cur_ready !== 1'b1) $display("FAIL b2b_write_ready: got %b required 1", cur_ready);
      else n_pass++;
      step();
      set_idle();
      @(negedge clk);
      n_checks++;
      if ({cur_ready, cur_rdata} !== {1'b1, 32'hDEADBEEF})
         $display("FAIL b2b_read: got rdy=%b rdata=%h required 1 deadbeef", cur_ready, cur_rdata);
      else n_pass++;
      step();
      @(negedge clk);
      n_checks++;
      if (cur_rdata !== 32'h0) $display("FAIL idle_rdata: got %h required 0", cur_rdata);
      else n_pass++;
      step();
   endtask

   task automatic test_byte_lanes();
      logic [31:0] d;
      target = 0;
      do_write(32'h20, HSIZE_WORD, 32'h11223344);
      do_write(32'h22, HSIZE_BYTE, 32'h5CAA5C5C);
      do_read(32'h20, d);
      n_checks++;
      if (d !== 32'h11AA3344) $display("FAIL byte_write: got %h required 11aa3344", d);
      else n_pass++;
      do_write(32'h20, HSIZE_HWORD, 32'h7777BEEF);
      do_read(32'h20, d);
      n_checks++;
      if (d !== 32'h11AABEEF) $display("FAIL half_low: got %h required 11aabeef", d);
      else n_pass++;
      do_write(32'h22, HSIZE_HWORD, 32'hCAFE0000);
      do_read(32'h20, d);
      n_checks++;
      if (d !== 32'hCAFEBEEF) $display("FAIL half_high: got %h required cafebeef", d);
      else n_pass++;
   endtask

   task automatic test_wait_states();
      target = 2;
      do_write(32'h0, HSIZE_WORD, 32'hCAFEF00D);
      addr_phase(1'b0, 32'h0, HSIZE_WORD);
      step();
      set_idle();
      @(negedge clk);
      n_checks++;
      if ({cur_ready, cur_rdata} !== {1'b0, 32'hCAFEF00D})
         $display("FAIL ws_wait1: got rdy=%b rdata=%h required 0 cafef00d", cur_ready, cur_rdata);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (cur_ready !== 1'b0) $display("FAIL ws_wait2: got rdy=%b required 0", cur_ready);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({cur_ready, cur_rdata} !== {1'b1, 32'hCAFEF00D})
         $display("FAIL ws_data: got rdy=%b rdata=%h required 1 cafef00d", cur_ready, cur_rdata);
      else n_pass++;
      step();
      for (int k = 0; k < 2; k++) begin
         hsel   = 1'b1;
         htrans = (k == 0) ? HTRANS_BUSY : HTRANS_IDLE;
         step();
         set_idle();
         @(negedge clk);
         n_checks++;
         if ({cur_ready, cur_resp} !== 2'b10)
            $display("FAIL ws_no_access_%0d: got rdy=%b resp=%b required 1 0",
                     k, cur_ready, cur_resp);
         else n_pass++;
         step();
      end
   endtask

   task automatic test_errors();
      logic [31:0] err_addr [4] = '{32'h1000, 32'h2, 32'h0, 32'h1000};
      logic [2:0]  err_size [4] = '{HSIZE_WORD, HSIZE_WORD, HSIZE_DWORD, HSIZE_WORD};
      int          err_tgt  [4] = '{0, 0, 0, 2};
      logic [31:0] d;
      for (int k = 0; k < 4; k++) begin
         target = err_tgt[k];
         addr_phase(1'b0, err_addr[k], err_size[k]);
         step();
         set_idle();
         @(negedge clk);
         n_checks++;
         if ({cur_ready, cur_resp} !== 2'b01)
            $display("FAIL err%0d_first: got rdy=%b resp=%b required 0 1", k, cur_ready, cur_resp);
         else n_pass++;
         step();
         @(negedge clk);
         n_checks++;
         if ({cur_ready, cur_resp} !== 2'b11)
            $display("FAIL err%0d_second: got rdy=%b resp=%b required 1 1", k, cur_ready, cur_resp);
         else n_pass++;
         step();
         @(negedge clk);
         n_checks++;
         if ({cur_ready, cur_resp} !== 2'b10)
            $display("FAIL err%0d_after: got rdy=%b resp=%b required 1 0", k, cur_ready, cur_resp);
         else n_pass++;
         step();
      end
      target = 0;
      addr_phase(1'b1, 32'h1010, HSIZE_WORD);
      step();
      hwdata = 32'h12345678;
      set_idle();
      step();
      step();
      addr_phase(1'b1, 32'h12, HSIZE_WORD);
      step();
      hwdata = 32'h87654321;
      set_idle();
      step();
      step();
      do_read(32'h10, d);
      n_checks++;
      if (d !== 32'hDEADBEEF) $display("FAIL err_write_kept: got %h required deadbeef", d);
      else n_pass++;
   endtask

   task automatic test_hready_low();
      logic [31:0] d;
      target = 0;
      stall  = 1'b1;
      hwdata = 32'h0BADF00D;
      addr_phase(1'b1, 32'h10, HSIZE_WORD);
      step();
      set_idle();
      stall = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({cur_ready, cur_resp} !== 2'b10)
         $display("FAIL hready_low_idle: got rdy=%b resp=%b required 1 0", cur_ready, cur_resp);
      else n_pass++;
      step();
      step();
      do_read(32'h10, d);
      n_checks++;
      if (d !== 32'hDEADBEEF) $display("FAIL hready_low_mem: got %h required deadbeef", d);
      else n_pass++;
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] d;
      target = 2;
      do_write(32'h40, HSIZE_WORD, 32'h13579BDF);
      addr_phase(1'b0, 32'h40, HSIZE_WORD);
      step();
      set_idle();
      @(negedge clk);
      n_checks++;
      if ({cur_ready, cur_rdata} !== {1'b0, 32'h13579BDF})
         $display("FAIL rst_pre: got rdy=%b rdata=%h required 0 13579bdf", cur_ready, cur_rdata);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({cur_ready, cur_resp, cur_rdata} !== {1'b1, 1'b0, 32'h0})
         $display("FAIL rst_mid_read: got rdy=%b resp=%b rdata=%h required 1 0 0",
                  cur_ready, cur_resp, cur_rdata);
      else n_pass++;
      #3 rst = 1'b0;
      addr_phase(1'b1, 32'h40, HSIZE_WORD);
      step();
      hwdata = 32'hFFFFFFFF;
      set_idle();
      @(negedge clk);
      #2 rst = 1'b1;
      #4 rst = 1'b0;
      step();
      do_read(32'h40, d);
      n_checks++;
      if (d !== 32'h13579BDF) $display("FAIL rst_write_dropped: got %h required 13579bdf", d);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_byte_lanes();
      test_wait_states();
      test_errors();
      test_hready_low();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
